// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and bubble constant for the pipeline stage latches
package pipe_pkg;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
endpackage

// File: rtl/pipe_skid_latch_reg_n.sv
// reg_n: WIDTH-bit register with load enable, load-value select and async active-low clear
module reg_n #(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             bubble,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge clr)
        if (!clr) q <= RESET_VAL;
        else if (en) q <= bubble ? RESET_VAL : d;
endmodule

// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch: registered valid/ready stage with a 2-entry skid buffer and bubble-inserting flush
module pipe_skid_latch
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = WIDTH'(NOP_WORD)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    state_t state, nxt;
    logic main_vld, skid_vld, acc, pop;
    logic main_en, main_bub, main_from_skid, skid_en, skid_bub;
    logic [WIDTH-1:0] main_q, skid_q;
    assign main_vld  = state != ST_EMPTY;
    assign skid_vld  = state == ST_FULL;
    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign occupancy = {skid_vld, main_vld & !skid_vld};
    assign out_data  = main_q;
    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;
    always_comb begin
        nxt = state;
        main_en = 1'b0;
        main_bub = 1'b0;
        main_from_skid = 1'b0;
        skid_en = 1'b0;
        skid_bub = 1'b0;
        if (flush) begin
            nxt = ST_EMPTY;
            {main_en, main_bub, skid_en, skid_bub} = 4'b1111;
        end else begin
            case (state)
                ST_EMPTY: if (acc) begin
                    main_en = 1'b1;
                    nxt = ST_ONE;
                end
                ST_ONE: begin
                    main_en = pop;
                    main_bub = pop & !acc;
                    skid_en = acc & !pop;
                    nxt = pop ? (acc ? ST_ONE : ST_EMPTY) : (acc ? ST_FULL : ST_ONE);
                end
                ST_FULL: if (pop) begin
                    {main_en, main_from_skid, skid_en, skid_bub} = 4'b1111;
                    nxt = ST_ONE;
                end
                // unreachable encoding recovers to an empty, bubbled stage
                default: begin
                    nxt = ST_EMPTY;
                    {main_en, main_bub, skid_en, skid_bub} = 4'b1111;
                end
            endcase
        end
    end
    always_ff @(posedge clk or negedge clr)
        if (!clr) state <= ST_EMPTY;
        else state <= nxt;
    reg_n #(.WIDTH(WIDTH), .RESET_VAL(BUBBLE_VAL)) u_main (
        .clk(clk), .clr(clr), .en(main_en), .bubble(main_bub),
        .d(main_from_skid ? skid_q : in_data), .q(main_q)
    );
    reg_n #(.WIDTH(WIDTH), .RESET_VAL(BUBBLE_VAL)) u_skid (
        .clk(clk), .clr(clr), .en(skid_en), .bubble(skid_bub),
        .d(in_data), .q(skid_q)
    );
endmodule

// File: tb/tb_pipe_skid_latch.sv
// tb_pipe_skid_latch: three width variants in lockstep, checked against vector tables and a queue model
module tb_pipe_skid_latch;
    localparam logic [31:0] B32 = 32'h0;
    localparam logic [0:0]  B1  = 1'b1;
    localparam logic [63:0] B64 = 64'hDEAD_BEEF_0000_0013;
    typedef struct {
        bit iv; logic [63:0] d; bit ordy; bit fl;
        bit ir; bit ov; logic [1:0] occ; logic [63:0] ed;
    } vec_t;
    logic clk = 0, clr = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [63:0] din = '0;
    logic r32, v32, r1, v1, r64, v64;
    logic [1:0] o32, o1, o64;
    logic [31:0] q32;
    logic [0:0] q1;
    logic [63:0] q64;
    logic [63:0] mq[$];
    vec_t tbl[$];
    int pass_cnt = 0, total = 0;
    always #5 clk = ~clk;
    pipe_skid_latch u32 (.clk(clk), .clr(clr), .flush(flush), .in_valid(in_valid), .in_ready(r32),
        .in_data(din[31:0]), .out_valid(v32), .out_ready(out_ready), .out_data(q32), .occupancy(o32));
    pipe_skid_latch #(.WIDTH(1), .BUBBLE_VAL(B1)) u1 (.clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(r1), .in_data(din[0:0]), .out_valid(v1), .out_ready(out_ready),
        .out_data(q1), .occupancy(o1));
    pipe_skid_latch #(.WIDTH(64), .BUBBLE_VAL(B64)) u64 (.clk(clk), .clr(clr), .flush(flush),
        .in_valid(in_valid), .in_ready(r64), .in_data(din), .out_valid(v64), .out_ready(out_ready),
        .out_data(q64), .occupancy(o64));
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask
    task automatic chk_all(string tag, bit ir, bit ov, logic [1:0] occ, logic [63:0] ed);
        chk({tag, " in_ready32"}, 64'(r32), 64'(ir));
        chk({tag, " in_ready1"}, 64'(r1), 64'(ir));
        chk({tag, " in_ready64"}, 64'(r64), 64'(ir));
        chk({tag, " out_valid32"}, 64'(v32), 64'(ov));
        chk({tag, " out_valid1"}, 64'(v1), 64'(ov));
        chk({tag, " out_valid64"}, 64'(v64), 64'(ov));
        chk({tag, " occ32"}, 64'(o32), 64'(occ));
        chk({tag, " occ1"}, 64'(o1), 64'(occ));
        chk({tag, " occ64"}, 64'(o64), 64'(occ));
        chk({tag, " data32"}, 64'(q32), ov ? 64'(ed[31:0]) : 64'(B32));
        chk({tag, " data1"}, 64'(q1), ov ? 64'(ed[0]) : 64'(B1));
        chk({tag, " data64"}, q64, ov ? ed : B64);
    endtask
    task automatic chk_model(string tag);
        logic [63:0] head;
        head = mq.size() != 0 ? mq[0] : 64'h0;
        chk_all(tag, mq.size() < 2, mq.size() != 0, 2'(mq.size()), head);
    endtask
    task automatic step(bit iv, logic [63:0] d, bit ordy, bit fl);
        bit acc, pop;
        @(negedge clk);
        in_valid = iv; din = d; out_ready = ordy; flush = fl;
        acc = iv && mq.size() < 2;
        pop = ordy && mq.size() != 0;
        @(posedge clk);
        if (fl) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(d);
        end
        #1 chk_model("model");
    endtask
    function automatic vec_t v(bit iv, logic [63:0] d, bit ordy, bit fl,
                               bit ir, bit ov, logic [1:0] occ, logic [63:0] ed);
        vec_t r;
        r = '{iv, d, ordy, fl, ir, ov, occ, ed};
        return r;
    endfunction
    initial begin
        for (int i = 1; i <= 10; i++) tbl.push_back(v(1, 64'(i), 1, 0, 1, 1, 1, 64'(i)));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(1, 64'hA, 0, 0, 1, 1, 1, 64'hA));
        tbl.push_back(v(1, 64'hB, 0, 0, 0, 1, 2, 64'hA));
        tbl.push_back(v(1, 64'hC, 0, 0, 0, 1, 2, 64'hA));
        tbl.push_back(v(1, 64'hC, 1, 0, 1, 1, 1, 64'hB));
        tbl.push_back(v(1, 64'hC, 1, 0, 1, 1, 1, 64'hC));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(1, 64'h11, 0, 0, 1, 1, 1, 64'h11));
        tbl.push_back(v(1, 64'h22, 0, 0, 0, 1, 2, 64'h11));
        tbl.push_back(v(1, 64'h33, 0, 1, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0, 0));
        repeat (3) begin
            @(negedge clk);
            #1 chk_all("reset", 1, 0, 0, 0);
        end
        @(negedge clk) clr = 1;
        repeat (3) step(0, 0, 0, 0);
        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl);
            chk_all($sformatf("vec%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].occ, tbl[i].ed);
        end
        step(1, 64'h55, 0, 0);
        step(1, 64'hFFFF_FFFF_FFFF_FF66, 0, 0);
        @(negedge clk);
        in_valid = 0;
        #2 clr = 0;
        mq.delete();
        #1 chk_all("async_clr", 1, 0, 0, 0);
        @(posedge clk);
        #1 chk_all("clr_held", 1, 0, 0, 0);
        @(negedge clk) clr = 1;
        repeat (400)
            step($urandom_range(3) != 0, {$urandom, $urandom}, $urandom_range(2) != 0, $urandom_range(24) == 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/pipe_skid_latch.md
Name: pipe_skid_latch

Overview:
- Parametrised successor to the fixed 32-bit pipeline stage latches.
- Carries one WIDTH-bit payload between two pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under backpressure. Both handshake sides are registered, so no combinational ready path crosses the stage.
- Synchronous flush inserts a bubble: valid is cleared and data is forced to BUBBLE_VAL. Used between fetch/decode/execute/memory stages and in front of the multdiv unit.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- BUBBLE_VAL, {WIDTH{1'b0}}, value driven on out_data whenever out_valid=0 (nop encoding).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-low reset (0 = reset).
- flush  input  1  synchronous flush; squashes all held entries.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept data this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage holds valid data.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  head payload.
- occupancy  output  2  entries held (0..2).

Behaviour:
- Definitions: acc = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main register (head) and skid register, each with its own valid bit.
- State register (2 bits): EMPTY, ONE, FULL.
- Decoded outputs, no combinational path from inputs:
  - in_ready = (state != FULL)
  - out_valid = (state != EMPTY)
  - occupancy = 0/1/2 for EMPTY/ONE/FULL
  - out_data = main register
- Reset (clr=0, asynchronous):
  - state=EMPTY; main=BUBBLE_VAL; skid=BUBBLE_VAL.
  - Outputs during reset: in_ready=1, out_valid=0, out_data=BUBBLE_VAL, occupancy=0.
  - Deassertion takes effect at the first following clk edge.
- Transitions, evaluated at the rising edge when flush=0:
  - EMPTY, acc: main<=in_data, go to ONE. Without acc: hold.
  - ONE, acc&pop: main<=in_data, stay ONE (full throughput, 1 transfer/cycle).
  - ONE, acc&!pop: skid<=in_data, go to FULL.
  - ONE, !acc&pop: main<=BUBBLE_VAL, go to EMPTY.
  - ONE, neither: hold.
  - FULL, pop: main<=skid, skid<=BUBBLE_VAL, go to ONE. acc is impossible in FULL (in_ready=0).
  - FULL, !pop: hold. Main and skid must be stable while out_ready=0.
- Flush (flush=1 at a rising edge):
  - Highest priority over all transitions.
  - state<=EMPTY; main<=BUBBLE_VAL; skid<=BUBBLE_VAL.
  - A transfer that handshakes in the flush cycle (in_valid=1, in_ready=1) is discarded. Upstream sees it as accepted.
  - A pop in the flush cycle still completes for the downstream. Its data is the pre-flush main value.
- Latency:
  - Data accepted at edge N appears on out_data, with out_valid=1, after edge N, i.e. 1 cycle.
  - Data is presented in strict FIFO order; no reordering or duplication.
- Invariants:
  - out_data == BUBBLE_VAL whenever out_valid=0.
  - Skid is only valid when main is valid.
  - Once out_valid=1, out_valid and out_data stay stable until pop or flush.
- Illegal state encoding (3): treated as EMPTY at the next edge.

Decomposition:
- Shared package pipe_pkg:
  - State constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Default bubble constant NOP_WORD=32'h0000_0000.
- One natural sub-module, reg_n:
  - WIDTH-parametrised register with load enable, synchronous load-value select, asynchronous active-low clear to a RESET_VAL parameter.
  - Generic successor to the fixed 32-bit register.
  - Instantiated twice: main and skid.
- State logic stays in pipe_skid_latch.

Test Plan:
- Reset/idle: hold clr=0 for 3 cycles, release, no traffic -> in_ready=1, out_valid=0, out_data=BUBBLE_VAL, occupancy=0 every cycle.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,...,10 on consecutive edges -> out_data 1..10 one cycle later, one per cycle, occupancy=1 throughout, in_ready never drops.
- Backpressure/skid: stream 0xA,0xB,0xC with out_ready=0 from the cycle 0xA is accepted:
  - 0xA in main, 0xB in skid, occupancy=2, in_ready=0, 0xC held upstream.
  - Raise out_ready -> output order 0xA,0xB,0xC, no loss or duplication.
- Flush while FULL: with occupancy=2 (0x11, 0x22) assert flush one cycle with in_valid=1, in_data=0x33 -> next cycle out_valid=0, occupancy=0, out_data=BUBBLE_VAL; 0x33 never appears at output.
- Async reset mid-operation: with occupancy=2, pull clr low between edges -> out_valid=0 and out_data=BUBBLE_VAL immediately, before the next edge.
- Parameter sweep: rerun streaming and backpressure scenarios with WIDTH=1, BUBBLE_VAL=1 and WIDTH=64, BUBBLE_VAL=64'hDEAD_BEEF_0000_0013 -> identical handshake timing; out_data equals BUBBLE_VAL whenever out_valid=0.
